// File: rtl/pa_out_queue.sv
// pa_out_queue: in-order output queue behind the page-walk unit's PA interface.
// Buffers translated PAs with their fault flags, decouples the consumer from
// PWU back-pressure and keeps fault statistics (saturating count, last faulted PA).
module pa_out_queue #(
  parameter int DEPTH = 4,
  parameter int PA_W  = 28,
  parameter int CNT_W = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [PA_W-1:0]            s_pa_i,
  input  logic                       s_pa_vld_i,
  input  logic                       s_pa_fault_i,
  output logic                       s_pa_rdy_o,
  output logic [PA_W-1:0]            m_pa_o,
  output logic                       m_pa_fault_o,
  output logic                       m_pa_vld_o,
  input  logic                       m_pa_rdy_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [CNT_W-1:0]           fault_cnt_o,
  output logic [PA_W-1:0]            last_fault_pa_o,
  input  logic                       stat_clr_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]    ZERO_CNT = {CW{1'b0}};
  localparam logic [CNT_W-1:0] SAT_CNT  = {CNT_W{1'b1}};

  // Occupancy encoding: bit1 is the upstream ready, bit0 is the head valid,
  // so both handshake outputs come straight from state flops.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'b10,
    OCC_PARTIAL = 2'b11,
    OCC_FULL    = 2'b01
  } occ_e;

  occ_e             occ_q, occ_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PA_W:0]    mem_q [DEPTH];
  logic [PA_W:0]    mem_d [DEPTH];
  logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
  logic [PA_W-1:0]  last_fault_pa_q, last_fault_pa_d;
  logic             push_s;
  logic             pop_s;

  assign s_pa_rdy_o      = occ_q[1];
  assign m_pa_vld_o      = occ_q[0];
  assign count_o         = count_q;
  assign fault_cnt_o     = fault_cnt_q;
  assign last_fault_pa_o = last_fault_pa_q;
  assign m_pa_fault_o    = mem_q[rd_ptr_q][PA_W];
  assign m_pa_o          = mem_q[rd_ptr_q][PA_W-1:0];

  assign push_s = s_pa_vld_i & s_pa_rdy_o;
  assign pop_s  = m_pa_vld_o & m_pa_rdy_i;

  // Next pointers, occupancy count and occupancy state from the handshakes.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    occ_d    = occ_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (count_d == ZERO_CNT) begin
      occ_d = OCC_EMPTY;
    end else if (count_d == FULL_CNT) begin
      occ_d = OCC_FULL;
    end else begin
      occ_d = OCC_PARTIAL;
    end
  end

  // Storage write: the payload is captured only on an accepted push.
  always_comb begin
    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = {s_pa_fault_i, s_pa_i};
    end else begin
      mem_d = mem_q;
    end
  end

  // Fault statistics; a clear wins over a faulted push in the same cycle.
  always_comb begin
    fault_cnt_d     = fault_cnt_q;
    last_fault_pa_d = last_fault_pa_q;
    if (stat_clr_i) begin
      fault_cnt_d     = {CNT_W{1'b0}};
      last_fault_pa_d = {PA_W{1'b0}};
    end else if (push_s && s_pa_fault_i) begin
      if (fault_cnt_q != SAT_CNT) begin
        fault_cnt_d = fault_cnt_q + CNT_W'(1);
      end else begin
        fault_cnt_d = fault_cnt_q;
      end
      last_fault_pa_d = s_pa_i;
    end else begin
      fault_cnt_d     = fault_cnt_q;
      last_fault_pa_d = last_fault_pa_q;
    end
  end

  // Occupancy state machine with pointers and count; reset drops all entries.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      occ_q    <= OCC_EMPTY;
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= ZERO_CNT;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is intentionally not reset; the head is masked by m_pa_vld_o.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  // Statistics registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fault_cnt_q     <= {CNT_W{1'b0}};
      last_fault_pa_q <= {PA_W{1'b0}};
    end else begin
      fault_cnt_q     <= fault_cnt_d;
      last_fault_pa_q <= last_fault_pa_d;
    end
  end

`ifndef SYNTHESIS
  pa_out_queue_chk #(
    .DEPTH (DEPTH),
    .PA_W  (PA_W)
  ) u_chk (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .s_pa_i       (s_pa_i),
    .s_pa_vld_i   (s_pa_vld_i),
    .s_pa_fault_i (s_pa_fault_i),
    .s_pa_rdy_o   (s_pa_rdy_o),
    .m_pa_vld_o   (m_pa_vld_o),
    .m_pa_rdy_i   (m_pa_rdy_i),
    .count_o      (count_o)
  );
`endif

endmodule

// pa_out_queue_chk: simulation-only protocol and occupancy checks.
module pa_out_queue_chk #(
  parameter int DEPTH = 4,
  parameter int PA_W  = 28
) (
  input logic                   clk_i,
  input logic                   reset_i,
  input logic [PA_W-1:0]        s_pa_i,
  input logic                   s_pa_vld_i,
  input logic                   s_pa_fault_i,
  input logic                   s_pa_rdy_o,
  input logic                   m_pa_vld_o,
  input logic                   m_pa_rdy_i,
  input logic [$clog2(DEPTH):0] count_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  a_no_push_full: assert property (@(posedge clk_i) disable iff (reset_i)
    (s_pa_vld_i && s_pa_rdy_o) |-> (count_o != CW'(DEPTH)));

  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (reset_i)
    (m_pa_vld_o && m_pa_rdy_i) |-> (count_o != {CW{1'b0}}));

  a_src_stable: assert property (@(posedge clk_i) disable iff (reset_i)
    (s_pa_vld_i && !s_pa_rdy_o) |=>
      (s_pa_vld_i && $stable(s_pa_i) && $stable(s_pa_fault_i)));

  a_occ_consistent: assert property (@(posedge clk_i) disable iff (reset_i)
    (s_pa_rdy_o == (count_o != CW'(DEPTH))) && (m_pa_vld_o == (count_o != {CW{1'b0}})));

endmodule
